transformation_block: RTL and testbench
=======================================

Name: transformation_block

Overview:
- Upstream neighbour of the combination stage. Computes FM_WM = FM × WM, where FM is FEATURE_ROWS×FEATURE_COLS and WM is FEATURE_COLS×WEIGHT_COLS.
- Uses one serial multiply-accumulate unit reading two single-port memories with 1-cycle read latency.
- Stores the FEATURE_ROWS×WEIGHT_COLS result in an internal buffer. The combination stage reads that buffer row-by-row via fm_wm_vector.
- done_trans drives the combination stage's start.

Parameters:
- FEATURE_ROWS, 6, rows of FM and FM_WM.
- FEATURE_COLS, 96, inner dimension (FM cols = WM rows).
- WEIGHT_COLS, 3, cols of WM and FM_WM.
- DATA_WIDTH, 5, unsigned FM/WM element width.
- DOT_PROD_WIDTH, 16, accumulator and result width.
- ADDRESS_WIDTH, 13, memory address width; must be ≥ clog2(max(FEATURE_ROWS, WEIGHT_COLS)×FEATURE_COLS).
- COUNTER_FEATURE_WIDTH, $clog2(FEATURE_ROWS), row index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (asserted when reset==0, sampled on posedge clk).
- start  in  1  level request to run one full transformation.
- fm_address  out  ADDRESS_WIDTH  FM read address, row-major: r×FEATURE_COLS+k.
- wm_address  out  ADDRESS_WIDTH  WM read address, column-major: c×FEATURE_COLS+k.
- enable_read  out  1  read strobe for both memories.
- fm_data  in  DATA_WIDTH  FM data, valid 1 cycle after the address/enable_read cycle.
- wm_data  in  DATA_WIDTH  WM data, same timing as fm_data.
- fm_wm_read_row  in  COUNTER_FEATURE_WIDTH  buffer row selected by the combination stage.
- fm_wm_vector  out  DOT_PROD_WIDTH×[0:WEIGHT_COLS-1]  buffer row fm_wm_read_row; combinational read of registered storage.
- done_trans  out  1  all FM_WM entries written.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; row/col/k counters=0; accumulator=0; all buffer entries=0.
  - fm_address=0, wm_address=0, enable_read=0, done_trans=0.
  - Applies mid-operation: the current computation is abandoned with no partial write.
- Loop order: c outer (0..WEIGHT_COLS-1), r middle (0..FEATURE_ROWS-1), k inner (0..FEATURE_COLS-1).
- FSM states:
  - IDLE: outputs idle. start==1 → FETCH, with r=c=k=0 and acc=0.
  - FETCH:
    - Drives enable_read=1 and addresses for the current k.
    - From the second FETCH cycle onward, adds fm_data×wm_data (data of k-1) to acc.
    - k increments each cycle; at k==FEATURE_COLS-1 → DRAIN.
  - DRAIN: enable_read=0; adds the last product (k=FEATURE_COLS-1) → WRITE.
  - WRITE:
    - buffer[r][c] <= acc; acc <= 0; k <= 0.
    - If r<FEATURE_ROWS-1: r++ → FETCH.
    - Else if c<WEIGHT_COLS-1: r=0, c++ → FETCH.
    - Else → DONE.
  - DONE: done_trans=1; buffer held. start==0 → IDLE, with done_trans falling on that transition. start held high → stay in DONE; no restart without a low-then-high start.
- start deasserted during FETCH/DRAIN/WRITE is ignored; the run completes.
- Latency: FEATURE_COLS+2 cycles per entry. With defaults, done_trans rises 6×3×98 = 1764 cycles after the first cycle start is seen in IDLE.
- Arithmetic:
  - Product is unsigned, 2×DATA_WIDTH bits, zero-extended to DOT_PROD_WIDTH.
  - Accumulation wraps modulo 2^DOT_PROD_WIDTH.
- fm_wm_vector:
  - Valid at any time and reflects buffer contents, which are 0 after reset.
  - fm_wm_read_row ≥ FEATURE_ROWS returns all zeros.
- A buffer write and a read of the same row in the same cycle returns the old value; the new value appears next cycle.

Optional Feature:
- Macro TRANS_SATURATE_EN.
- Defined: any accumulate whose true sum exceeds 2^DOT_PROD_WIDTH−1 clamps acc to all-ones. The clamp is sticky until acc clears in WRITE.
- Undefined: accumulation wraps modulo 2^DOT_PROD_WIDTH as above.

Test Plan:
- Defaults, all FM=1, all WM=2, start pulse held until done:
  - every fm_wm_vector entry is 192;
  - done_trans rises exactly 1764 cycles after start;
  - enable_read is high for 96 of every 98 cycles.
- FM[r][k]=r+1, WM[k][c]=c (k<4 nonzero, rest 0):
  - row r reads {0, 4(r+1), 8(r+1)};
  - first address pair is fm=0/wm=0;
  - address pair after the first WRITE is fm=96/wm=0.
- All FM=WM=31:
  - without macro: entries = 92256 mod 65536 = 26720;
  - with TRANS_SATURATE_EN: entries = 65535.
- Reset driven low for one cycle at cycle 500 of a run:
  - next cycle shows state IDLE, done_trans=0, all fm_wm_vector rows 0;
  - with start held high, a fresh run completes 1764 cycles later with correct values.
- start held high after done_trans:
  - stays in DONE with no new reads;
  - dropping start for 1 cycle then raising it reruns the computation and done_trans pulses low for ≥1 cycle.
- fm_wm_read_row=7 (out of range):
  - fm_wm_vector = {0, 0, 0} while valid rows read correctly in the same run.

Source files
------------

// File: rtl/transformation_block.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : transformation_block
// Purpose  : Serial MAC computing FM_WM = FM x WM into a row-readable buffer.
//            Optional macro TRANS_SATURATE_EN clamps the accumulator instead
//            of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module transformation_block #(
  parameter int FEATURE_ROWS          = 6,
  parameter int FEATURE_COLS          = 96,
  parameter int WEIGHT_COLS           = 3,
  parameter int DATA_WIDTH            = 5,
  parameter int DOT_PROD_WIDTH        = 16,
  parameter int ADDRESS_WIDTH         = 13,
  parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic [ADDRESS_WIDTH-1:0]         fm_address,
  output logic [ADDRESS_WIDTH-1:0]         wm_address,
  output logic                             enable_read,
  input  logic [DATA_WIDTH-1:0]            fm_data,
  input  logic [DATA_WIDTH-1:0]            wm_data,
  input  logic [COUNTER_FEATURE_WIDTH-1:0] fm_wm_read_row,
  output logic [DOT_PROD_WIDTH-1:0]        fm_wm_vector [0:WEIGHT_COLS-1],
  output logic                             done_trans
);

  localparam int c_k_width   = (FEATURE_COLS > 1) ? $clog2(FEATURE_COLS) : 1;
  localparam int c_col_width = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
  localparam int c_prod_width = 2 * DATA_WIDTH;

  localparam logic [c_k_width-1:0]             c_k_last   = c_k_width'(FEATURE_COLS - 1);
  localparam logic [c_col_width-1:0]           c_col_last = c_col_width'(WEIGHT_COLS - 1);
  localparam logic [COUNTER_FEATURE_WIDTH-1:0] c_row_last = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);
  localparam logic [COUNTER_FEATURE_WIDTH:0]   c_rows     = (COUNTER_FEATURE_WIDTH + 1)'(FEATURE_ROWS);
  localparam logic [ADDRESS_WIDTH-1:0]         c_fcols    = ADDRESS_WIDTH'(FEATURE_COLS);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_fetch = 3'd1;
  localparam logic [2:0] c_st_drain = 3'd2;
  localparam logic [2:0] c_st_write = 3'd3;
  localparam logic [2:0] c_st_done  = 3'd4;

  logic [2:0]                       r_state;
  logic [2:0]                       w_next_state;
  logic [COUNTER_FEATURE_WIDTH-1:0] r_row;
  logic [c_col_width-1:0]           r_col;
  logic [c_k_width-1:0]             r_k;
  logic [DOT_PROD_WIDTH-1:0]        r_acc;
  logic                             r_rd_valid;
  logic [DOT_PROD_WIDTH-1:0]        r_buffer [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1];

  logic [c_prod_width-1:0]          w_product;
  logic [DOT_PROD_WIDTH-1:0]        w_acc_next;
  logic [ADDRESS_WIDTH-1:0]         w_fm_addr;
  logic [ADDRESS_WIDTH-1:0]         w_wm_addr;

  assign w_product = {{DATA_WIDTH{1'b0}}, fm_data} * {{DATA_WIDTH{1'b0}}, wm_data};

`ifdef TRANS_SATURATE_EN
  logic [DOT_PROD_WIDTH:0] w_sum;
  assign w_sum      = {1'b0, r_acc} + {{(DOT_PROD_WIDTH + 1 - c_prod_width){1'b0}}, w_product};
  // Saturated acc stays all-ones since any further nonzero add overflows again.
  assign w_acc_next = w_sum[DOT_PROD_WIDTH] ? {DOT_PROD_WIDTH{1'b1}} : w_sum[DOT_PROD_WIDTH-1:0];
`else
  assign w_acc_next = r_acc + {{(DOT_PROD_WIDTH - c_prod_width){1'b0}}, w_product};
`endif

  assign w_fm_addr = c_fcols * ADDRESS_WIDTH'(r_row) + ADDRESS_WIDTH'(r_k);
  assign w_wm_addr = c_fcols * ADDRESS_WIDTH'(r_col) + ADDRESS_WIDTH'(r_k);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= c_st_idle;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:  if (start) w_next_state = c_st_fetch;
      c_st_fetch: if (r_k == c_k_last) w_next_state = c_st_drain;
      c_st_drain: w_next_state = c_st_write;
      c_st_write: begin
        if (r_row != c_row_last || r_col != c_col_last) w_next_state = c_st_fetch;
        else                                            w_next_state = c_st_done;
      end
      c_st_done:  if (!start) w_next_state = c_st_idle;
      default:    w_next_state = c_st_idle;
    endcase
  end

  always_comb begin
    enable_read = 1'b0;
    fm_address  = '0;
    wm_address  = '0;
    done_trans  = 1'b0;
    case (r_state)
      c_st_fetch: begin
        enable_read = 1'b1;
        fm_address  = w_fm_addr;
        wm_address  = w_wm_addr;
      end
      c_st_done:  done_trans = 1'b1;
      default:    ;
    endcase
  end

  // r_rd_valid marks the cycle where memory data belongs to the previous FETCH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_row      <= '0;
      r_col      <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_rd_valid <= 1'b0;
      for (int i = 0; i < FEATURE_ROWS; i++)
        for (int j = 0; j < WEIGHT_COLS; j++)
          r_buffer[i][j] <= '0;
    end else begin
      r_rd_valid <= (r_state == c_st_fetch);
      if (r_rd_valid) r_acc <= w_acc_next;
      case (r_state)
        c_st_idle: begin
          r_row <= '0;
          r_col <= '0;
          r_k   <= '0;
          r_acc <= '0;
        end
        c_st_fetch: if (r_k != c_k_last) r_k <= r_k + 1'b1;
        c_st_write: begin
          r_buffer[r_row][r_col] <= r_acc;
          r_acc <= '0;
          r_k   <= '0;
          if (r_row != c_row_last) begin
            r_row <= r_row + 1'b1;
          end else begin
            r_row <= '0;
            if (r_col != c_col_last) r_col <= r_col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int c = 0; c < WEIGHT_COLS; c++) begin
      fm_wm_vector[c] = '0;
      if ({1'b0, fm_wm_read_row} < c_rows) fm_wm_vector[c] = r_buffer[fm_wm_read_row][c];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_transformation_block.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_transformation_block
// Purpose  : Directed, table-driven check of transformation_block.
// Revision : 1.0 - initial release
// ============================================================================
module tb_transformation_block;

  localparam int FR = 6;
  localparam int FC = 96;
  localparam int WC = 3;
  localparam int LAT = FR * WC * (FC + 2);
`ifdef TRANS_SATURATE_EN
  localparam logic [15:0] BIG_EXP = 16'd65535;
`else
  localparam logic [15:0] BIG_EXP = 16'd26720;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [12:0] fm_address;
  logic [12:0] wm_address;
  logic        enable_read;
  logic [4:0]  fm_data = '0;
  logic [4:0]  wm_data = '0;
  logic [2:0]  fm_wm_read_row;
  logic [15:0] fm_wm_vector [0:WC-1];
  logic        done_trans;

  logic [4:0] fm_mem [0:FR*FC-1];
  logic [4:0] wm_mem [0:WC*FC-1];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          mode;
    logic [2:0]  row;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [15:0] e2;
  } rd_vec_t;

  rd_vec_t tbl [0:11];

  transformation_block dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .fm_address     (fm_address),
    .wm_address     (wm_address),
    .enable_read    (enable_read),
    .fm_data        (fm_data),
    .wm_data        (wm_data),
    .fm_wm_read_row (fm_wm_read_row),
    .fm_wm_vector   (fm_wm_vector),
    .done_trans     (done_trans)
  );

  always #10 clk = ~clk;

  // Single-port memories with one-cycle read latency
  always @(posedge clk) begin
    if (enable_read) begin
      fm_data <= fm_mem[fm_address];
      wm_data <= wm_mem[wm_address];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input int mode);
    for (int r = 0; r < FR; r++)
      for (int k = 0; k < FC; k++)
        fm_mem[r*FC+k] = (mode == 0) ? 5'd1 : (mode == 1) ? 5'(r + 1) : 5'd31;
    for (int c = 0; c < WC; c++)
      for (int k = 0; k < FC; k++)
        wm_mem[c*FC+k] = (mode == 0) ? 5'd2 : (mode == 1) ? ((k < 4) ? 5'(c) : 5'd0) : 5'd31;
  endtask

  // Call at a negedge with the DUT in IDLE; start is held high afterwards.
  task automatic run_trans(output int lat, output int en_cnt,
                           output int a1f, output int a1w, output int a2f, output int a2w);
    int   rises;
    logic prev;
    start = 1'b1;
    lat = 0; en_cnt = 0; rises = 0; prev = 1'b0;
    a1f = -1; a1w = -1; a2f = -1; a2w = -1;
    @(posedge clk);
    while (lat <= LAT + 200) begin
      #1;
      if (done_trans) break;
      if (enable_read) begin
        en_cnt++;
        if (!prev) begin
          rises++;
          if (rises == 1) begin a1f = int'(fm_address); a1w = int'(wm_address); end
          if (rises == 2) begin a2f = int'(fm_address); a2w = int'(wm_address); end
        end
      end
      prev = enable_read;
      @(posedge clk);
      lat++;
    end
    if (!done_trans) begin
      errors++; checks++;
      $display("FAIL run_timeout: done_trans never rose, waited %0d cycles", lat);
    end
  endtask

  task automatic check_table(input int mode);
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].mode == mode) begin
        @(negedge clk);
        fm_wm_read_row = tbl[i].row;
        #1;
        chk($sformatf("m%0d_row%0d_c0", mode, tbl[i].row), int'(fm_wm_vector[0]), int'(tbl[i].e0));
        chk($sformatf("m%0d_row%0d_c1", mode, tbl[i].row), int'(fm_wm_vector[1]), int'(tbl[i].e1));
        chk($sformatf("m%0d_row%0d_c2", mode, tbl[i].row), int'(fm_wm_vector[2]), int'(tbl[i].e2));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int r = 0; r < 8; r++) begin
      fm_wm_read_row = 3'(r);
      #1;
      for (int c = 0; c < WC; c++)
        chk($sformatf("%s_row%0d_c%0d", tag, r, c), int'(fm_wm_vector[c]), 0);
    end
  endtask

  initial begin
    int lat, en_cnt, a1f, a1w, a2f, a2w, held_reads;

    tbl[0]  = '{0, 3'd0, 16'd192, 16'd192, 16'd192};
    tbl[1]  = '{0, 3'd3, 16'd192, 16'd192, 16'd192};
    tbl[2]  = '{0, 3'd5, 16'd192, 16'd192, 16'd192};
    tbl[3]  = '{0, 3'd7, 16'd0,   16'd0,   16'd0};
    tbl[4]  = '{1, 3'd0, 16'd0,   16'd4,   16'd8};
    tbl[5]  = '{1, 3'd1, 16'd0,   16'd8,   16'd16};
    tbl[6]  = '{1, 3'd4, 16'd0,   16'd20,  16'd40};
    tbl[7]  = '{1, 3'd5, 16'd0,   16'd24,  16'd48};
    tbl[8]  = '{1, 3'd7, 16'd0,   16'd0,   16'd0};
    tbl[9]  = '{2, 3'd0, BIG_EXP, BIG_EXP, BIG_EXP};
    tbl[10] = '{2, 3'd5, BIG_EXP, BIG_EXP, BIG_EXP};
    tbl[11] = '{2, 3'd6, 16'd0,   16'd0,   16'd0};

    reset = 1'b0; start = 1'b0; fm_wm_read_row = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", int'(done_trans), 0);
    chk("rst_en", int'(enable_read), 0);
    chk("rst_fm_addr", int'(fm_address), 0);
    chk("rst_wm_addr", int'(wm_address), 0);
    check_all_zero("rst");
    @(negedge clk);
    reset = 1'b1;

    // All FM=1, WM=2
    load(0);
    @(negedge clk);
    run_trans(lat, en_cnt, a1f, a1w, a2f, a2w);
    chk("m0_latency", lat, LAT);
    chk("m0_read_cycles", en_cnt, FR * WC * FC);
    check_table(0);

    // start held after done: no new reads, done stays high
    held_reads = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (enable_read) held_reads++;
    end
    chk("held_done", int'(done_trans), 1);
    chk("held_reads", held_reads, 0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("done_fall", int'(done_trans), 0);

    // FM=r+1, WM=c for k<4
    load(1);
    @(negedge clk);
    run_trans(lat, en_cnt, a1f, a1w, a2f, a2w);
    chk("m1_latency", lat, LAT);
    chk("m1_first_fm", a1f, 0);
    chk("m1_first_wm", a1w, 0);
    chk("m1_second_fm", a2f, FC);
    chk("m1_second_wm", a2w, 0);
    check_table(1);

    // All 31: overflow behaviour
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    load(2);
    @(negedge clk);
    run_trans(lat, en_cnt, a1f, a1w, a2f, a2w);
    chk("m2_latency", lat, LAT);
    check_table(2);

    // Reset mid-run at cycle 500, then a fresh run with start held high
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    load(0);
    @(negedge clk);
    start = 1'b1;
    repeat (500) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_done", int'(done_trans), 0);
    chk("mid_rst_en", int'(enable_read), 0);
    check_all_zero("mid_rst");
    @(negedge clk);
    reset = 1'b1;
    run_trans(lat, en_cnt, a1f, a1w, a2f, a2w);
    chk("post_rst_latency", lat, LAT);
    check_table(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
